// File: rtl/mig_bus_arbiter_pkg.sv
// Shared types and width helpers for the MIG bus round-robin arbiter.
// Request slice: {valid, addr, wdata, wstrb}; response slice: {rdata, ready}.
package mig_bus_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned req_width(int unsigned addr_w, int unsigned data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int unsigned resp_width(int unsigned data_w);
    return data_w + 1;
  endfunction

  // Index width, never below one bit so a single-master build still has a gnt port.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mig_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request scanning upward from
// last+1 with wrap-around.
module mig_arb_rr_pick
  import mig_bus_arbiter_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned PAD_W = 1 << IDX_W;

  logic [PAD_W-1:0] req_pad;
  logic [IDX_W-1:0] cand;

  assign req_pad = PAD_W'(req);

  // Walk from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = IDX_W'((32'(last) + 32'(k) + 32'd1) % N);
      if (req_pad[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mig_bus_arbiter.sv
// Round-robin arbiter sharing one MIG native bus among N cache back-ends.
// Optional per-master grant counters are built when MIG_ARB_CNT_EN is defined.
module mig_bus_arbiter
  import mig_bus_arbiter_pkg::*;
#(
  parameter  int unsigned N_MASTERS = 4,
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned DATA_W    = 256,
`ifdef MIG_ARB_CNT_EN
  parameter  int unsigned CNT_W     = 32,
`endif
  localparam int unsigned REQ_W     = req_width(ADDR_W, DATA_W),
  localparam int unsigned RESP_W    = resp_width(DATA_W),
  localparam int unsigned GNT_W     = idx_width(N_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef MIG_ARB_CNT_EN
  input  logic                          cnt_clr,
  output logic [N_MASTERS*CNT_W-1:0]    grant_cnt,
`endif
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp,
  output logic                          busy,
  output logic [GNT_W-1:0]              gnt
);

  arb_state_e       state_q, state_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [GNT_W-1:0] last_q, last_d;
  logic [N_MASTERS-1:0] req_valid;
  logic             pick_found;
  logic [GNT_W-1:0] pick_idx;

  for (genvar i = 0; i < int'(N_MASTERS); i++) begin : g_valid
    assign req_valid[i] = m_req[i*REQ_W + REQ_W - 1];
  end

  mig_arb_rr_pick #(
    .N (N_MASTERS)
  ) u_pick (
    .req   (req_valid),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state: grant in IDLE, hold the grant until the slave signals ready.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          gnt_d   = pick_idx;
          last_d  = pick_idx;
        end
      end
      ST_BUSY: begin
        if (s_resp[0]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= GNT_W'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign gnt  = gnt_q;

  // Granted request passes straight through; the bus is quiet in IDLE.
  always_comb begin
    s_req = '0;
    if (busy) begin
      for (int i = 0; i < int'(N_MASTERS); i++) begin
        if (gnt_q == GNT_W'(i)) s_req = m_req[i*REQ_W +: REQ_W];
      end
    end
  end

  for (genvar i = 0; i < int'(N_MASTERS); i++) begin : g_resp
    assign m_resp[i*RESP_W +: RESP_W] =
      busy ? {s_resp[RESP_W-1:1], s_resp[0] & (gnt_q == GNT_W'(i))} : '0;
  end

`ifdef MIG_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_MASTERS];
  logic             grant_ev;

  assign grant_ev = (state_q == ST_IDLE) && pick_found;

  // Saturating grant counters; clear takes priority over a same-cycle grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_MASTERS); i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < int'(N_MASTERS); i++) cnt_q[i] <= '0;
    end else if (grant_ev) begin
      for (int i = 0; i < int'(N_MASTERS); i++) begin
        if ((pick_idx == GNT_W'(i)) && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < int'(N_MASTERS); i++) begin : g_cnt
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_mig_bus_arbiter.sv
// Scoreboard bench for mig_bus_arbiter: directed stimulus pushes expected
// completions, a monitor checks them whenever a master sees ready.
`timescale 1ns/1ps
module tb_mig_bus_arbiter;
  localparam int unsigned N      = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + DATA_W/8;
  localparam int unsigned RESP_W = DATA_W + 1;
  localparam int unsigned CNT_W  = 2;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N*REQ_W-1:0]    m_req;
  logic [N*RESP_W-1:0]   m_resp;
  logic [REQ_W-1:0]      s_req;
  logic [RESP_W-1:0]     s_resp;
  logic                  busy;
  logic [1:0]            gnt;
  logic [REQ_W-1:0]      mreq [N];
`ifdef MIG_ARB_CNT_EN
  logic                  cnt_clr;
  logic [N*CNT_W-1:0]    grant_cnt;
`endif

  exp_t              expq[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                done     = 0;
  int                scnt     = 0;
  int                lat      = 3;
  int                base;
  logic [DATA_W-1:0] rdata_cfg;

  always #5 clk = ~clk;
  assign m_req = {mreq[3], mreq[2], mreq[1], mreq[0]};

  mig_bus_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (ADDR_W),
`ifdef MIG_ARB_CNT_EN
    .CNT_W     (CNT_W),
`endif
    .DATA_W    (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MIG_ARB_CNT_EN
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt),
`endif
    .m_req     (m_req),
    .m_resp    (m_resp),
    .s_req     (s_req),
    .s_resp    (s_resp),
    .busy      (busy),
    .gnt       (gnt)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] make_req(input int i, input logic v);
    logic [ADDR_W-1:0]   a = 32'h8000_0000 + 32'(i) * 32'h40;
    logic [DATA_W-1:0]   d = {8{32'hC0DE_0000 | 32'(i)}};
    logic [DATA_W/8-1:0] s = {4{8'(8'h11 * (i + 1))}};
    return {v, a, d, s};
  endfunction

  task automatic wait_done(input int target);
    for (int c = 0; c < 60 && done < target; c++) begin
      @(negedge clk); #3;
    end
    chk("done_count", 512'(done), 512'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Slave model: ready with rdata_cfg once the grant has lasted more than lat cycles.
  initial begin
    s_resp = '0;
    forever begin
      @(negedge clk);
      if (busy) begin
        scnt++;
        s_resp = (scnt > lat) ? {rdata_cfg, 1'b1} : '0;
      end else begin
        scnt   = 0;
        s_resp = '0;
      end
    end
  end

  // Monitor: every master-side ready must match the head of the scoreboard.
  initial begin
    logic [N-1:0] rdy;
    exp_t         e;
    forever begin
      @(negedge clk); #2;
      for (int i = 0; i < int'(N); i++) rdy[i] = m_resp[i*RESP_W];
      if (|rdy) begin
        if (expq.size() == 0) begin
          chk("unexpected_ready", 512'(rdy), 512'(0));
        end else begin
          e = expq.pop_front();
          chk("ready_onehot", 512'(rdy), 512'(1) << e.idx);
          chk("gnt_at_ready", 512'(gnt), 512'(e.idx));
          chk("s_req_passthru", 512'(s_req), 512'(mreq[e.idx]));
          for (int i = 0; i < int'(N); i++)
            chk($sformatf("rdata_bcast%0d", i), 512'(m_resp[i*RESP_W+1 +: DATA_W]), 512'(e.rdata));
        end
        done++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < int'(N); i++) mreq[i] = '0;
    rdata_cfg = '0;
`ifdef MIG_ARB_CNT_EN
    cnt_clr = 1'b0;
`endif
    #1;
    chk("reset_s_req", 512'(s_req), 512'(0));
    chk("reset_m_resp", 512'(m_resp), 512'(0));
    chk("reset_busy", 512'(busy), 512'(0));
    chk("reset_gnt", 512'(gnt), 512'(0));
`ifdef MIG_ARB_CNT_EN
    chk("reset_grant_cnt", 512'(grant_cnt), 512'(0));
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single request from master 2.
    @(negedge clk); #3;
    rdata_cfg = {8{32'h1234_5678}};
    expq.push_back('{2, rdata_cfg});
    mreq[2] = make_req(2, 1'b1);
    @(negedge clk); #3;
    chk("single_busy", 512'(busy), 512'(1));
    chk("single_gnt", 512'(gnt), 512'(2));
    chk("single_s_req", 512'(s_req), 512'(mreq[2]));
    wait_done(1);
    mreq[2][REQ_W-1] = 1'b0;
    @(negedge clk); #3;
    chk("single_idle", 512'(busy), 512'(0));
    chk("single_gnt_kept", 512'(gnt), 512'(2));

    // Fairness: all masters request continuously after reset.
    do_reset();
    #3;
    base = done;
    rdata_cfg = {8{32'h0BAD_F00D}};
    foreach (expq[i]) chk("queue_before_rr", 512'(expq.size()), 512'(0));
    for (int k = 0; k < 5; k++) expq.push_back('{k % 4, rdata_cfg});
    for (int i = 0; i < int'(N); i++) mreq[i] = make_req(i, 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_done(base + k + 1);
      if (k < 4) begin
        @(negedge clk); #3;
        chk("rr_gap_idle", 512'(busy), 512'(0));
        @(negedge clk); #3;
        chk("rr_regrant", 512'(busy), 512'(1));
      end
    end
    for (int i = 0; i < int'(N); i++) mreq[i][REQ_W-1] = 1'b0;

    // Isolation: master 1 granted while master 3 waits.
    @(negedge clk); #3;
    base = done;
    rdata_cfg = {32{8'hA5}};
    expq.push_back('{1, rdata_cfg});
    expq.push_back('{3, rdata_cfg});
    mreq[1] = make_req(1, 1'b1);
    mreq[3] = make_req(3, 1'b1);
    @(negedge clk); #3;
    chk("iso_gnt_first", 512'(gnt), 512'(1));
    wait_done(base + 1);
    mreq[1][REQ_W-1] = 1'b0;
    wait_done(base + 2);
    mreq[3][REQ_W-1] = 1'b0;

    // Reset in the middle of a transfer.
    @(negedge clk); #3;
    mreq[2] = make_req(2, 1'b1);
    @(negedge clk); #3;
    chk("mid_busy", 512'(busy), 512'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_s_req", 512'(s_req), 512'(0));
    chk("mid_rst_m_resp", 512'(m_resp), 512'(0));
    chk("mid_rst_gnt", 512'(gnt), 512'(0));
    base = done;
    rdata_cfg = {8{32'h5EED_0001}};
    mreq[0] = make_req(0, 1'b1);
    expq.push_back('{0, rdata_cfg});
    expq.push_back('{2, rdata_cfg});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #3;
    chk("post_rst_gnt", 512'(gnt), 512'(0));
    wait_done(base + 1);
    mreq[0][REQ_W-1] = 1'b0;
    wait_done(base + 2);
    mreq[2][REQ_W-1] = 1'b0;

    // Granted master drops valid before the slave answers.
    @(negedge clk); #3;
    base = done;
    expq.push_back('{3, rdata_cfg});
    mreq[3] = make_req(3, 1'b1);
    @(negedge clk); #3;
    mreq[3][REQ_W-1] = 1'b0;
    @(negedge clk); #3;
    chk("drop_busy", 512'(busy), 512'(1));
    chk("drop_gnt", 512'(gnt), 512'(3));
    chk("drop_s_valid", 512'(s_req[REQ_W-1]), 512'(0));
    wait_done(base + 1);
    @(negedge clk); #3;
    chk("drop_idle", 512'(busy), 512'(0));

`ifdef MIG_ARB_CNT_EN
    // Counter saturation and clear-over-increment.
    do_reset();
    #3;
    base = done;
    for (int k = 0; k < 5; k++) expq.push_back('{0, rdata_cfg});
    mreq[0] = make_req(0, 1'b1);
    wait_done(base + 5);
    mreq[0][REQ_W-1] = 1'b0;
    @(negedge clk); #3;
    chk("cnt_saturated", 512'(grant_cnt[CNT_W-1:0]), 512'(3));
    expq.push_back('{0, rdata_cfg});
    mreq[0][REQ_W-1] = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk); #3;
    cnt_clr = 1'b0;
    chk("cnt_clear_wins", 512'(grant_cnt[CNT_W-1:0]), 512'(0));
    chk("cnt_clear_busy", 512'(busy), 512'(1));
    wait_done(base + 6);
    mreq[0][REQ_W-1] = 1'b0;
`endif

    repeat (4) @(negedge clk);
    #3;
    chk("queue_drained", 512'(expq.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
